core5_cpu_oci_dct_packer: RTL
=============================

Name: core5_cpu_oci_dct_packer

Overview:
- Upstream producer of the OCI data-compression trace (DCT) state consumed by the CPU OCI test bench.
- Packs 2-bit trace atoms into a 30-bit shift buffer (15 atoms) with a 4-bit occupancy count.
- Emits full or flushed frames through a one-entry valid/ready output register to the trace memory path.
- Sits between the CPU trace-atom generator and the OCI trace FIFO.

Parameters:
- DROP_CNT_W, 8, width of the saturating dropped-atom counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- trace_enable  in  1  atoms are accepted only while high.
- atom_valid  in  1  atom present this cycle.
- atom  in  2  trace atom code.
- flush  in  1  single-cycle pulse; requests emission of a partial buffer.
- frame_ready  in  1  downstream accepts the frame when frame_valid is also high.
- dct_buffer  out  30  live packing buffer; newest atom in [29:28].
- dct_count  out  4  atoms currently held, 0..15.
- frame_valid  out  1  output frame register occupied.
- frame_data  out  34  {count[3:0], buffer[29:0]}.
- overflow  out  1  sticky; set on first dropped atom.
- drop_count  out  DROP_CNT_W  saturating count of dropped atoms.

Behaviour:
- Reset (async, reset_n=0): dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, overflow=0, drop_count=0, flush_pending=0. Reset mid-frame discards all buffered data with no emission.
- accept = trace_enable & atom_valid.
- out_free = !frame_valid | frame_ready.
- emit = out_free & (dct_count==15 | (flush_pending & dct_count!=0)).
- flush_pending is set by flush and cleared on emit. A flush arriving while dct_count==0 with no pending flush has no effect and leaves flush_pending=0.
- Shift rule: new_buf = {atom, buf[29:2]}. After k atoms the oldest atom sits at bits [31-2k:30-2k]. Unused low bits are 0.
- Emit cycle:
  - frame_data <= {dct_count, dct_buffer} and frame_valid <= 1.
  - If accept in the same cycle: dct_buffer <= {atom, 28'b0} and dct_count <= 1. Otherwise both are cleared to 0.
- Non-emit cycle with dct_count<15 and accept: shift and increment.
- Non-emit cycle with dct_count==15 and accept: the atom is dropped, overflow <= 1, and drop_count increments, saturating at all-ones.
- Full frame latency: the atom that makes count 15 is accepted in cycle N. frame_valid rises in cycle N+1 if out_free at N+1; otherwise it is held until the first out_free cycle.
- Output handshake:
  - frame_data is stable while frame_valid & !frame_ready.
  - frame_ready & frame_valid without emit clears frame_valid next cycle.
  - frame_ready & emit in the same cycle loads the new frame back-to-back (frame_valid stays 1).
- flush together with accept in the same cycle: the atom is counted first, and the flush is pending from the next cycle.
- trace_enable low: no accepts. Pending emission and flush still proceed.
- drop_count and overflow are cleared only by reset.

Test Plan:
- 15 atoms 2'b01..., trace_enable=1, frame_ready=1 -> dct_count climbs 1..15. Next cycle frame_valid=1, frame_data={4'hF, 30'h15555555}, dct_count=0.
- 3 atoms 2'b11, 2'b10, 2'b01, then flush pulse, frame_ready=1 -> frame_data={4'h3, 30'h1B000000} (bits [29:24]=6'b011011) one cycle after the flush.
- frame_ready=0 with one frame held, 15 more atoms, then 2 further atoms -> dct_count stays 15, overflow=1, drop_count=2. frame_ready=1 -> first frame drains, second loads back-to-back.
- Atom accepted on the emit cycle after count=15 -> emitted frame excludes it; dct_count=1, dct_buffer[29:28]=atom.
- Flush with dct_count=0 -> frame_valid stays 0 and no later spurious frame. Flush while output busy -> partial frame emitted the first cycle frame_ready=1.
- reset_n asserted asynchronously mid-cycle at dct_count=9, flush_pending=1 -> all outputs 0 immediately, no frame after release.

Source files
------------

// File: rtl/core5_cpu_oci_dct_packer.sv
// core5_cpu_oci_dct_packer: packs 2-bit trace atoms into 30-bit DCT frames for the OCI trace FIFO
//   clk, reset_n            : clock, asynchronous active-low reset
//   trace_enable, atom_valid: atom is accepted when both are high
//   atom                    : 2-bit trace atom code
//   flush                   : pulse requesting emission of a partial buffer
//   frame_ready             : downstream accepts frame_data while frame_valid is high
//   dct_buffer, dct_count   : live packing buffer (newest atom in [29:28]) and atoms held
//   frame_valid, frame_data : one-entry output register, {count, buffer}
//   overflow, drop_count    : sticky drop flag and saturating count of dropped atoms
module core5_cpu_oci_dct_packer #(
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  trace_enable,
   input  logic                  atom_valid,
   input  logic [1:0]            atom,
   input  logic                  flush,
   input  logic                  frame_ready,
   output logic [29:0]           dct_buffer,
   output logic [3:0]            dct_count,
   output logic                  frame_valid,
   output logic [33:0]           frame_data,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);
   logic flush_pending;
   logic accept;
   logic out_free;
   logic full;
   logic emit;
   always_comb begin
      accept   = trace_enable & atom_valid;
      out_free = !frame_valid | frame_ready;
      full     = dct_count == 4'd15;
      emit     = out_free & (full | (flush_pending & (dct_count != 4'd0)));
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dct_buffer    <= '0;
         dct_count     <= '0;
         frame_valid   <= 1'b0;
         frame_data    <= '0;
         overflow      <= 1'b0;
         drop_count    <= '0;
         flush_pending <= 1'b0;
      end else begin
         if (emit) begin
            frame_data  <= {dct_count, dct_buffer};
            frame_valid <= 1'b1;
            dct_buffer  <= accept ? {atom, 28'b0} : '0;
            dct_count   <= accept ? 4'd1 : 4'd0;
         end else begin
            if (frame_ready)
               frame_valid <= 1'b0;
            if (accept && !full) begin
               dct_buffer <= {atom, dct_buffer[29:2]};
               dct_count  <= dct_count + 4'd1;
            end
            if (accept && full) begin
               overflow <= 1'b1;
               if (!(&drop_count))
                  drop_count <= drop_count + 1'b1;
            end
         end
         // a flush only matters if something is (or is about to be) buffered
         flush_pending <= emit ? (flush & accept)
                               : (flush_pending | (flush & (accept | (dct_count != 4'd0))));
      end
   end
endmodule
